ct_mmu_sysmap_cfg: RTL and testbench

//  Programmable writer side of the sysmap table. Holds ENTRY_NUM region upper-bound addresses (PA[39:12]) and 5-bit attribute flags.

---
 rtl/ct_mmu_sysmap_cfg_pkg.sv | 33 +++
 rtl/ct_mmu_sysmap_cfg_entry.sv | 62 ++++++
 rtl/ct_mmu_sysmap_cfg.sv | 183 ++++++++++++++++++
 tb/tb_ct_mmu_sysmap_cfg.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ct_mmu_sysmap_cfg_pkg.sv
// ============================================================================
// Module   : ct_mmu_sysmap_cfg_pkg
// Brief    : Shared constants for the sysmap configuration block: register
//            index map, reset defaults and FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ct_mmu_sysmap_cfg_pkg;

  // Geometry defaults
  localparam int SYSMAP_ENTRY_NUM  = 8;
  localparam int SYSMAP_ADDR_WIDTH = 28;
  localparam int SYSMAP_FLG_WIDTH  = 5;

  // Reset values of every base/flag (shadow and active)
  localparam logic [27:0] DFLT_BASE = 28'hfffffff;
  localparam logic [4:0]  DFLT_FLG  = 5'b10011;

  // Register index map
  localparam logic [4:0] SYSMAP_IDX_BASE = 5'd0;
  localparam logic [4:0] SYSMAP_IDX_FLG  = 5'd8;
  localparam logic [4:0] SYSMAP_IDX_CTRL = 5'd16;

  // Commit FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ct_mmu_sysmap_cfg_entry.sv
// ============================================================================
// Module   : ct_mmu_sysmap_cfg_entry
// Brief    : One sysmap region: shadow base/flag written by software and an
//            active copy loaded from the shadow on commit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ct_mmu_sysmap_cfg_entry #(
  parameter int                    ADDR_WIDTH = 28,
  parameter int                    FLG_WIDTH  = 5,
  parameter logic [ADDR_WIDTH-1:0] DFLT_BASE  = '1,
  parameter logic [FLG_WIDTH-1:0]  DFLT_FLG   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_base_we,
  input  logic                  i_flg_we,
  input  logic [ADDR_WIDTH-1:0] i_base_wdata,
  input  logic [FLG_WIDTH-1:0]  i_flg_wdata,
  input  logic                  i_load,
  output logic [ADDR_WIDTH-1:0] o_shd_base,
  output logic [FLG_WIDTH-1:0]  o_shd_flg,
  output logic [ADDR_WIDTH-1:0] o_act_base,
  output logic [FLG_WIDTH-1:0]  o_act_flg
);

  logic [ADDR_WIDTH-1:0] r_shd_base;
  logic [FLG_WIDTH-1:0]  r_shd_flg;
  logic [ADDR_WIDTH-1:0] r_act_base;
  logic [FLG_WIDTH-1:0]  r_act_flg;

  // Shadow copy: updated by individual software writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shd_base <= DFLT_BASE;
      r_shd_flg  <= DFLT_FLG;
    end else begin
      if (i_base_we) r_shd_base <= i_base_wdata;
      if (i_flg_we)  r_shd_flg  <= i_flg_wdata;
    end
  end

  // Active copy: loaded from shadow only on the commit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_base <= DFLT_BASE;
      r_act_flg  <= DFLT_FLG;
    end else if (i_load) begin
      r_act_base <= r_shd_base;
      r_act_flg  <= r_shd_flg;
    end
  end

  assign o_shd_base = r_shd_base;
  assign o_shd_flg  = r_shd_flg;
  assign o_act_base = r_act_base;
  assign o_act_flg  = r_act_flg;

endmodule

`default_nettype wire

// File: rtl/ct_mmu_sysmap_cfg.sv
// ============================================================================
// Module   : ct_mmu_sysmap_cfg
// Brief    : Programmable writer side of the sysmap table. Register port
//            writes a shadow table; a commit checks monotonic ordering, waits
//            for the MMU to be idle, then atomically loads the active table.
// Options  : SYSMAP_CFG_LOCK_EN - enables the sticky configuration lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ct_mmu_sysmap_cfg
  import ct_mmu_sysmap_cfg_pkg::*;
#(
  parameter int                    ENTRY_NUM  = SYSMAP_ENTRY_NUM,
  parameter int                    ADDR_WIDTH = SYSMAP_ADDR_WIDTH,
  parameter int                    FLG_WIDTH  = SYSMAP_FLG_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] DFLT_BASE  = ct_mmu_sysmap_cfg_pkg::DFLT_BASE,
  parameter logic [FLG_WIDTH-1:0]  DFLT_FLG   = ct_mmu_sysmap_cfg_pkg::DFLT_FLG
) (
  input  logic                            forever_cpuclk,
  input  logic                            cpurst,
  input  logic                            regs_sysmap_req,
  input  logic                            regs_sysmap_wen,
  input  logic [4:0]                      regs_sysmap_idx,
  input  logic [63:0]                     regs_sysmap_wdata,
  output logic                            sysmap_regs_ack,
  output logic [63:0]                     sysmap_regs_rdata,
  input  logic                            mmu_sysmap_idle,
  output logic [ENTRY_NUM*ADDR_WIDTH-1:0] sysmap_base_addr_flat,
  output logic [ENTRY_NUM*FLG_WIDTH-1:0]  sysmap_flg_flat,
  output logic                            sysmap_cfg_upd
);

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  r_ack;
  logic [63:0]           r_rdata;
  logic                  r_upd;
  logic                  r_err;
  logic                  w_locked;
  logic                  w_accept;
  logic                  w_wr_cfg;
  logic                  w_commit_req;
  logic                  w_ordered;
  logic                  w_load;
  logic                  w_chk_fail;
  logic                  w_busy;
  logic [63:0]           w_rd_data;
  logic [ENTRY_NUM-1:0]  w_base_we;
  logic [ENTRY_NUM-1:0]  w_flg_we;
  logic [ENTRY_NUM-1:0]  w_ord;
  logic [ADDR_WIDTH-1:0] w_shd_base [ENTRY_NUM];
  logic [FLG_WIDTH-1:0]  w_shd_flg  [ENTRY_NUM];
  logic                  w_unused_wdata;

  // Reads are always served; writes only when no commit is in progress.
  // Requests seen during the ack cycle are ignored so acks never stack.
  assign w_accept     = regs_sysmap_req && !r_ack && (!regs_sysmap_wen || (r_state == ST_IDLE));
  assign w_wr_cfg     = w_accept && regs_sysmap_wen && !w_locked;
  assign w_commit_req = w_wr_cfg && (regs_sysmap_idx == SYSMAP_IDX_CTRL) && regs_sysmap_wdata[0];
  assign w_ordered    = &w_ord;

  assign w_unused_wdata = &{1'b0, regs_sysmap_wdata[63:ADDR_WIDTH]};

  genvar n;
  generate
    for (n = 0; n < ENTRY_NUM; n++) begin : g_entry
      assign w_base_we[n] = w_wr_cfg && (regs_sysmap_idx == SYSMAP_IDX_BASE + 5'(n));
      assign w_flg_we[n]  = w_wr_cfg && (regs_sysmap_idx == SYSMAP_IDX_FLG + 5'(n));

      ct_mmu_sysmap_cfg_entry #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .FLG_WIDTH  (FLG_WIDTH),
        .DFLT_BASE  (DFLT_BASE),
        .DFLT_FLG   (DFLT_FLG)
      ) u_entry (
        .clk          (forever_cpuclk),
        .rst          (cpurst),
        .i_base_we    (w_base_we[n]),
        .i_flg_we     (w_flg_we[n]),
        .i_base_wdata (regs_sysmap_wdata[ADDR_WIDTH-1:0]),
        .i_flg_wdata  (regs_sysmap_wdata[FLG_WIDTH-1:0]),
        .i_load       (w_load),
        .o_shd_base   (w_shd_base[n]),
        .o_shd_flg    (w_shd_flg[n]),
        .o_act_base   (sysmap_base_addr_flat[n*ADDR_WIDTH +: ADDR_WIDTH]),
        .o_act_flg    (sysmap_flg_flat[n*FLG_WIDTH +: FLG_WIDTH])
      );

      // Monotonic chain: each upper bound must not be below its predecessor
      if (n == 0) begin : g_ord_first
        assign w_ord[n] = 1'b1;
      end else begin : g_ord_rest
        assign w_ord[n] = (w_shd_base[n-1] <= w_shd_base[n]);
      end
    end
  endgenerate

  // FSM state register
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_commit_req) w_state_nxt = ST_CHECK;
      ST_CHECK:  w_state_nxt = w_ordered ? ST_WAIT : ST_IDLE;
      ST_WAIT:   if (mmu_sysmap_idle) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_load     = (r_state == ST_COMMIT);
    w_chk_fail = (r_state == ST_CHECK) && !w_ordered;
    w_busy     = (r_state != ST_IDLE);
  end

  // Read mux: shadow values zero-extended, control returns status
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (regs_sysmap_idx == SYSMAP_IDX_BASE + 5'(i)) w_rd_data[ADDR_WIDTH-1:0] = w_shd_base[i];
      if (regs_sysmap_idx == SYSMAP_IDX_FLG + 5'(i))  w_rd_data[FLG_WIDTH-1:0]  = w_shd_flg[i];
    end
    if (regs_sysmap_idx == SYSMAP_IDX_CTRL) w_rd_data[2:0] = {w_locked, r_err, w_busy};
  end

  // Ack pulse and read data capture
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_accept;
      r_rdata <= (w_accept && !regs_sysmap_wen) ? w_rd_data : 64'd0;
    end
  end

  // Update pulse follows the commit edge; error is sticky until a good commit
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_upd <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_upd <= w_load;
      if (w_chk_fail)  r_err <= 1'b1;
      else if (w_load) r_err <= 1'b0;
    end
  end

`ifdef SYSMAP_CFG_LOCK_EN
  logic r_lock_req;
  logic r_locked;

  // Lock request travels with the commit and takes hold once it lands
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_lock_req <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      if (w_commit_req)          r_lock_req <= regs_sysmap_wdata[1];
      if (w_load && r_lock_req)  r_locked   <= 1'b1;
    end
  end

  assign w_locked = r_locked;
`else
  assign w_locked = 1'b0;
`endif

  assign sysmap_regs_ack   = r_ack;
  assign sysmap_regs_rdata = r_rdata;
  assign sysmap_cfg_upd    = r_upd;

endmodule

`default_nettype wire

// File: tb/tb_ct_mmu_sysmap_cfg.sv
// ============================================================================
// Module   : tb_ct_mmu_sysmap_cfg
// Brief    : Directed self-checking bench for ct_mmu_sysmap_cfg.
//            Honours SYSMAP_CFG_LOCK_EN for the lock expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ct_mmu_sysmap_cfg;

  logic         clk;
  logic         rst;
  logic         req;
  logic         wen;
  logic [4:0]   idx;
  logic [63:0]  wdata;
  logic         ack;
  logic [63:0]  rdata;
  logic         idle;
  logic [223:0] base_flat;
  logic [39:0]  flg_flat;
  logic         upd;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;
  int u0;

  logic [63:0] rd_val;
  logic        acked;

`ifdef SYSMAP_CFG_LOCK_EN
  localparam logic [63:0] EXP_LOCK_STATUS = 64'h4;
  localparam logic [63:0] EXP_LOCKED_RD   = 64'h100;
`else
  localparam logic [63:0] EXP_LOCK_STATUS = 64'h0;
  localparam logic [63:0] EXP_LOCKED_RD   = 64'h0;
`endif

  ct_mmu_sysmap_cfg dut (
    .forever_cpuclk        (clk),
    .cpurst                (rst),
    .regs_sysmap_req       (req),
    .regs_sysmap_wen       (wen),
    .regs_sysmap_idx       (idx),
    .regs_sysmap_wdata     (wdata),
    .sysmap_regs_ack       (ack),
    .sysmap_regs_rdata     (rdata),
    .mmu_sysmap_idle       (idle),
    .sysmap_base_addr_flat (base_flat),
    .sysmap_flg_flat       (flg_flat),
    .sysmap_cfg_upd        (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count update pulses, sampled mid-cycle
  always @(negedge clk) if (upd === 1'b1) upd_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic w, input logic [4:0] i, input logic [63:0] d,
                        input int budget, output logic [63:0] r, output logic a);
    @(negedge clk);
    req = 1'b1; wen = w; idx = i; wdata = d;
    a = 1'b0; r = '0;
    for (int k = 0; k < budget && !a; k++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin a = 1'b1; r = rdata; end
    end
    req = 1'b0;
  endtask

  task automatic wr(input logic [4:0] i, input logic [63:0] d, input string tag);
    logic [63:0] r; logic a;
    access(1'b1, i, d, 8, r, a);
    check(tag, {63'd0, a}, 64'd1);
  endtask

  task automatic rd(input logic [4:0] i, input logic [63:0] exp, input string tag);
    logic [63:0] r; logic a;
    access(1'b0, i, 64'd0, 8, r, a);
    check({tag, "_ack"}, {63'd0, a}, 64'd1);
    check(tag, r, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] base_out(input int n);
    return {36'd0, base_flat[n*28 +: 28]};
  endfunction

  function automatic logic [63:0] flg_out(input int n);
    return {59'd0, flg_flat[n*5 +: 5]};
  endfunction

  initial begin
    rst = 1'b1; req = 1'b0; wen = 1'b0; idx = '0; wdata = '0; idle = 1'b1;
    cycles(3);
    check("rst_base_flat", {32'd0, base_flat[31:0]}, {32'd0, {4'hf, 28'hfffffff}});
    check("rst_base_hi", base_out(7), 64'hfffffff);
    check("rst_flg_flat", {24'd0, flg_flat}, {24'd0, {8{5'b10011}}});
    check("rst_upd", {63'd0, upd}, 64'd0);
    check("rst_ack", {63'd0, ack}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    @(negedge clk); rst = 1'b0;

    // 1: reset readback and reserved index behaviour
    rd(5'd0, 64'hfffffff, "rd_base0_dflt");
    rd(5'd8, 64'h13, "rd_flg0_dflt");
    wr(5'd20, 64'hffff, "wr_resv");
    rd(5'd20, 64'h0, "rd_resv");
    rd(5'd16, 64'h0, "rd_status_dflt");

    // 2: basic commit
    u0 = upd_cnt;
    wr(5'd0, 64'h80000, "wr_base0");
    for (int n = 1; n < 8; n++) wr(5'(n), 64'hfffffff, "wr_base_n");
    wr(5'd8, 64'h0f, "wr_flg0");
    cycles(2);
    check("active_before_commit", base_out(0), 64'hfffffff);
    wr(5'd16, 64'h1, "wr_commit");
    cycles(8);
    check("upd_once", 64'(upd_cnt - u0), 64'd1);
    check("base0_out", base_out(0), 64'h80000);
    check("flg0_out", flg_out(0), 64'h0f);
    check("base1_out", base_out(1), 64'hfffffff);
    rd(5'd16, 64'h0, "status_after_commit");

    // 3: ordering violation, then repair
    u0 = upd_cnt;
    wr(5'd0, 64'h200, "wr_base0_bad");
    wr(5'd1, 64'h100, "wr_base1_bad");
    wr(5'd16, 64'h1, "wr_commit_bad");
    cycles(6);
    rd(5'd16, 64'h2, "status_err");
    check("no_upd_bad", 64'(upd_cnt - u0), 64'd0);
    check("base0_unchanged", base_out(0), 64'h80000);
    wr(5'd1, 64'h300, "wr_base1_fix");
    wr(5'd16, 64'h1, "wr_commit_fix");
    cycles(8);
    rd(5'd16, 64'h0, "status_fixed");
    check("base0_fixed", base_out(0), 64'h200);
    check("base1_fixed", base_out(1), 64'h300);
    check("upd_fixed", 64'(upd_cnt - u0), 64'd1);

    // 4: commit held off by a busy MMU; writes stall, reads proceed
    idle = 1'b0;
    u0 = upd_cnt;
    wr(5'd2, 64'h400, "wr_base2");
    wr(5'd16, 64'h1, "wr_commit_wait");
    cycles(10);
    rd(5'd16, 64'h1, "status_busy");
    check("base2_held", base_out(2), 64'hfffffff);
    access(1'b1, 5'd3, 64'h500, 5, rd_val, acked);
    check("stalled_wr_noack", {63'd0, acked}, 64'd0);
    rd(5'd2, 64'h400, "rd_during_wait");
    check("no_upd_wait", 64'(upd_cnt - u0), 64'd0);
    @(negedge clk);
    req = 1'b1; wen = 1'b1; idx = 5'd3; wdata = 64'h500;
    cycles(2);
    @(negedge clk); idle = 1'b1;
    acked = 1'b0;
    for (int k = 0; k < 10 && !acked; k++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        acked = 1'b1;
        check("upd_before_stalled_ack", 64'(upd_cnt - u0), 64'd1);
      end
    end
    req = 1'b0;
    check("stalled_wr_ack", {63'd0, acked}, 64'd1);
    cycles(2);
    check("base2_out", base_out(2), 64'h400);
    check("base3_active_old", base_out(3), 64'hfffffff);
    rd(5'd3, 64'h500, "rd_base3");

    // 5: reset while waiting for the MMU
    idle = 1'b0;
    wr(5'd16, 64'h1, "wr_commit_rst");
    cycles(4);
    rd(5'd16, 64'h1, "status_busy_rst");
    u0 = upd_cnt;
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("async_rst_base0", base_out(0), 64'hfffffff);
    check("async_rst_flg0", flg_out(0), 64'h13);
    cycles(2);
    @(negedge clk); rst = 1'b0; idle = 1'b1;
    cycles(6);
    check("no_upd_after_rst", 64'(upd_cnt - u0), 64'd0);
    check("base2_after_rst", base_out(2), 64'hfffffff);
    rd(5'd0, 64'hfffffff, "rd_base0_after_rst");
    rd(5'd16, 64'h0, "status_after_rst");

    // 6: commit with lock request
    wr(5'd0, 64'h100, "wr_base0_lock");
    wr(5'd16, 64'h3, "wr_commit_lock");
    cycles(8);
    check("base0_lock_commit", base_out(0), 64'h100);
    rd(5'd16, EXP_LOCK_STATUS, "status_lock");
    wr(5'd0, 64'h0, "wr_base0_locked");
    rd(5'd0, EXP_LOCKED_RD, "rd_base0_locked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
